// File: rtl/heap_arbiter.sv
// heap_arbiter
// Two-client front end for the linked-memory allocator. Grants at most one
// client command per cycle, registers it onto the allocator strobes/operands,
// and routes the allocator result back to the issuing client two cycles later.
// A latched halt state follows any allocator error or an invalid opcode.
//
// Ports
//   i_clk, i_rst              clock, async active-high reset
//   i_reqK/i_opK/i_argK/i_valK client K command (held until o_ackK)
//   o_ackK                    combinational grant pulse
//   o_rspK/o_rsltK            response valid pulse and value (0 when idle)
//   o_alloc/o_free/o_rd/o_wr  registered allocator strobes
//   o_data/o_faddr/o_raddr/o_waddr/o_wdata  registered allocator operands
//   i_aaddr/i_rdata/i_err     allocator result and error/halt
//   o_err                     arbiter halted
//
// state | meaning
// INIT  | waiting for allocator power-up hold (i_err) to drop; no grants
// RUN   | normal arbitration
// HALT  | error latched; no grants, responses suppressed, exit by reset only
module heap_arbiter #(
  parameter int DATA_SZ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req0,
  input  logic               i_req1,
  input  logic [2:0]         i_op0,
  input  logic [2:0]         i_op1,
  input  logic [DATA_SZ-1:0] i_arg0,
  input  logic [DATA_SZ-1:0] i_arg1,
  input  logic [DATA_SZ-1:0] i_val0,
  input  logic [DATA_SZ-1:0] i_val1,
  output logic               o_ack0,
  output logic               o_ack1,
  output logic               o_rsp0,
  output logic               o_rsp1,
  output logic [DATA_SZ-1:0] o_rslt0,
  output logic [DATA_SZ-1:0] o_rslt1,
  output logic               o_alloc,
  output logic               o_free,
  output logic               o_rd,
  output logic               o_wr,
  output logic [DATA_SZ-1:0] o_data,
  output logic [DATA_SZ-1:0] o_faddr,
  output logic [DATA_SZ-1:0] o_raddr,
  output logic [DATA_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  input  logic [DATA_SZ-1:0] i_aaddr,
  input  logic [DATA_SZ-1:0] i_rdata,
  input  logic               i_err,
  output logic               o_err
);

  localparam logic [2:0] OP_ALLOC   = 3'b001;
  localparam logic [2:0] OP_FREE    = 3'b010;
  localparam logic [2:0] OP_RECYCLE = 3'b011;
  localparam logic [2:0] OP_READ    = 3'b100;
  localparam logic [2:0] OP_WRITE   = 3'b101;

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HALT} state_t;
  typedef enum logic [1:0] {K_NONE, K_ADDR, K_DATA} kind_t;

  state_t state_q, state_d;
  logic   prio_q, prio_d;

  logic alloc_q, alloc_d, free_q, free_d, rd_q, rd_d, wr_q, wr_d;
  logic [DATA_SZ-1:0] data_q, data_d, faddr_q, faddr_d;
  logic [DATA_SZ-1:0] raddr_q, raddr_d, waddr_q, waddr_d, wdata_q, wdata_d;

  // tag stage 1 lines up with the strobes, stage 2 with the allocator result
  logic  t1_v_q, t1_v_d, t1_c_q, t1_c_d;
  kind_t t1_k_q, t1_k_d;
  logic  t2_v_q, t2_c_q;
  kind_t t2_k_q;

  logic gnt0, gnt1, gnt, op_ok, rsp_live;
  logic [2:0]         sel_op;
  logic [DATA_SZ-1:0] sel_arg, sel_val, rsp_val;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    prio_d  = prio_q;
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (i_req0 && (!i_req1 || !prio_q)) gnt0 = 1'b1;
      else if (i_req1)                    gnt1 = 1'b1;
      // pointer only moves when both clients were competing
      if (i_req0 && i_req1) prio_d = ~prio_q;
    end
    gnt     = gnt0 | gnt1;
    sel_op  = gnt1 ? i_op1  : i_op0;
    sel_arg = gnt1 ? i_arg1 : i_arg0;
    sel_val = gnt1 ? i_val1 : i_val0;
    op_ok   = (sel_op >= OP_ALLOC) && (sel_op <= OP_WRITE);

    alloc_d = 1'b0;
    free_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    data_d  = data_q;
    faddr_d = faddr_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    t1_v_d  = 1'b0;
    t1_c_d  = gnt1;
    t1_k_d  = K_NONE;

    if (gnt && op_ok) begin
      t1_v_d = 1'b1;
      case (sel_op)
        OP_ALLOC: begin
          alloc_d = 1'b1; data_d = sel_val; t1_k_d = K_ADDR;
        end
        OP_FREE: begin
          free_d = 1'b1; faddr_d = sel_arg;
        end
        OP_RECYCLE: begin
          alloc_d = 1'b1; free_d = 1'b1;
          data_d = sel_val; faddr_d = sel_arg; t1_k_d = K_ADDR;
        end
        OP_READ: begin
          rd_d = 1'b1; raddr_d = sel_arg; t1_k_d = K_DATA;
        end
        default: begin
          wr_d = 1'b1; waddr_d = sel_arg; wdata_d = sel_val;
        end
      endcase
    end

    case (state_q)
      ST_INIT: if (!i_err) state_d = ST_RUN;
      ST_RUN:  if (i_err || (gnt && !op_ok)) state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      prio_q  <= 1'b0;
      alloc_q <= 1'b0;
      free_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      faddr_q <= '0;
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      t1_v_q  <= 1'b0;
      t1_c_q  <= 1'b0;
      t1_k_q  <= K_NONE;
      t2_v_q  <= 1'b0;
      t2_c_q  <= 1'b0;
      t2_k_q  <= K_NONE;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      alloc_q <= alloc_d;
      free_q  <= free_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      faddr_q <= faddr_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      t1_v_q  <= t1_v_d;
      t1_c_q  <= t1_c_d;
      t1_k_q  <= t1_k_d;
      t2_v_q  <= t1_v_q;
      t2_c_q  <= t1_c_q;
      t2_k_q  <= t1_k_q;
    end
  end

  always_comb begin
    rsp_val = '0;
    case (t2_k_q)
      K_ADDR:  rsp_val = i_aaddr;
      K_DATA:  rsp_val = i_rdata;
      default: rsp_val = '0;
    endcase
  end

  assign rsp_live = t2_v_q && (state_q != ST_HALT);
  assign o_rsp0   = rsp_live && !t2_c_q;
  assign o_rsp1   = rsp_live &&  t2_c_q;
  assign o_rslt0  = o_rsp0 ? rsp_val : '0;
  assign o_rslt1  = o_rsp1 ? rsp_val : '0;
  assign o_ack0   = gnt0;
  assign o_ack1   = gnt1;
  assign o_alloc  = alloc_q;
  assign o_free   = free_q;
  assign o_rd     = rd_q;
  assign o_wr     = wr_q;
  assign o_data   = data_q;
  assign o_faddr  = faddr_q;
  assign o_raddr  = raddr_q;
  assign o_waddr  = waddr_q;
  assign o_wdata  = wdata_q;
  assign o_err    = (state_q == ST_HALT);

endmodule

// File: tb/tb_heap_arbiter.sv
`timescale 1ns/1ps
module tb_heap_arbiter;

  localparam logic [2:0] OP_ALLOC   = 3'b001;
  localparam logic [2:0] OP_RECYCLE = 3'b011;
  localparam logic [2:0] OP_READ    = 3'b100;
  localparam logic [2:0] OP_WRITE   = 3'b101;

  logic        i_clk = 1'b0;
  logic        i_rst, i_req0, i_req1, i_err;
  logic [2:0]  i_op0, i_op1;
  logic [15:0] i_arg0, i_arg1, i_val0, i_val1;
  logic [15:0] i_aaddr = 16'h0, i_rdata = 16'h0;
  logic        o_ack0, o_ack1, o_rsp0, o_rsp1;
  logic [15:0] o_rslt0, o_rslt1;
  logic        o_alloc, o_free, o_rd, o_wr, o_err;
  logic [15:0] o_data, o_faddr, o_raddr, o_waddr, o_wdata;

  int n_chk  = 0;
  int n_fail = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  logic [15:0] next_addr = 16'h5000;
  logic [15:0] mem [0:255];

  heap_arbiter #(.DATA_SZ(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0(i_req0), .i_req1(i_req1), .i_op0(i_op0), .i_op1(i_op1),
    .i_arg0(i_arg0), .i_arg1(i_arg1), .i_val0(i_val0), .i_val1(i_val1),
    .o_ack0(o_ack0), .o_ack1(o_ack1), .o_rsp0(o_rsp0), .o_rsp1(o_rsp1),
    .o_rslt0(o_rslt0), .o_rslt1(o_rslt1),
    .o_alloc(o_alloc), .o_free(o_free), .o_rd(o_rd), .o_wr(o_wr),
    .o_data(o_data), .o_faddr(o_faddr), .o_raddr(o_raddr),
    .o_waddr(o_waddr), .o_wdata(o_wdata),
    .i_aaddr(i_aaddr), .i_rdata(i_rdata), .i_err(i_err), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // allocator stub: hands out sequential addresses from 16'h5000, small memory
  always @(posedge i_clk) begin
    if (o_alloc) begin
      i_aaddr   <= next_addr;
      next_addr <= next_addr + 16'h1;
    end
    if (o_wr) mem[o_waddr[7:0]] <= o_wdata;
    if (o_rd) i_rdata <= mem[o_raddr[7:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // response monitor
  always @(negedge i_clk) begin
    if (o_rsp0 || o_rsp1) begin
      chk("rsp_onehot", 32'(o_rsp0 & o_rsp1), 32'd0);
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_client", 32'(o_rsp1), 32'(mon_e[16]));
        chk("rsp_value", 32'(o_rsp1 ? o_rslt1 : o_rslt0), 32'(mon_e[15:0]));
        chk("rsp_other_zero", 32'(o_rsp1 ? o_rslt0 : o_rslt1), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    i_rst = 1'b1; i_err = 1'b1;
    i_req0 = 1'b1; i_op0 = OP_ALLOC; i_arg0 = 16'h0; i_val0 = 16'h1234;
    i_req1 = 1'b0; i_op1 = 3'b000;   i_arg1 = 16'h0; i_val1 = 16'h0;
    #2;
    chk("reset_outputs", 32'({o_ack0, o_ack1, o_rsp0, o_rsp1, o_alloc, o_free, o_rd, o_wr, o_err}), 32'd0);
    chk("reset_operands", 32'(o_data | o_faddr | o_raddr | o_waddr | o_wdata | o_rslt0 | o_rslt1), 32'd0);
    repeat (2) step();
    i_rst = 1'b0;

    // startup hold
    bad = 0;
    repeat (60) begin
      step();
      if (o_ack0 || o_ack1) bad++;
    end
    chk("startup_no_ack", 32'(bad), 32'd0);
    i_err = 1'b0;
    #1 chk("ack_in_err_fall_cycle", 32'(o_ack0), 32'd0);
    step();
    chk("startup_ack", 32'(o_ack0), 32'd1);
    exp_q.push_back({1'b0, 16'h5000});
    step();
    i_req0 = 1'b0;
    chk("startup_alloc", 32'(o_alloc), 32'd1);
    chk("startup_data", 32'(o_data), 32'h1234);
    repeat (4) step();

    // contention
    i_req0 = 1'b1; i_op0 = OP_ALLOC; i_val0 = 16'h0A0A;
    i_req1 = 1'b1; i_op1 = OP_ALLOC; i_val1 = 16'h0B0B;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("contend_ack", 32'({o_ack1, o_ack0}), (i % 2 == 0) ? 32'd1 : 32'd2);
      exp_q.push_back({(i % 2 == 1), 16'h5001 + 16'(i)});
      step();
    end
    i_req0 = 1'b0; i_req1 = 1'b0;
    repeat (4) step();

    // write then read from client 1
    i_req1 = 1'b1; i_op1 = OP_WRITE; i_arg1 = 16'h5003; i_val1 = 16'hBEEF;
    #1 chk("write_ack", 32'(o_ack1), 32'd1);
    exp_q.push_back({1'b1, 16'h0000});
    step();
    i_op1 = OP_READ;
    #1 chk("read_ack", 32'(o_ack1), 32'd1);
    exp_q.push_back({1'b1, 16'hBEEF});
    chk("write_strobes", 32'({o_wr, o_rd}), 32'd2);
    chk("write_operands", {o_waddr, o_wdata}, 32'h5003BEEF);
    step();
    i_req1 = 1'b0;
    chk("read_strobes", 32'({o_wr, o_rd}), 32'd1);
    chk("read_addr", 32'(o_raddr), 32'h5003);
    repeat (4) step();

    // recycle from client 0
    i_req0 = 1'b1; i_op0 = OP_RECYCLE; i_arg0 = 16'h5002; i_val0 = 16'h0007;
    #1 chk("recycle_ack", 32'(o_ack0), 32'd1);
    exp_q.push_back({1'b0, 16'h5007});
    step();
    i_req0 = 1'b0;
    chk("recycle_strobes", 32'({o_alloc, o_free, o_rd, o_wr}), 32'hC);
    chk("recycle_operands", {o_faddr, o_data}, 32'h50020007);
    repeat (4) step();

    // invalid opcode halts
    i_req1 = 1'b1; i_op1 = 3'b111;
    #1 chk("invalid_ack", 32'(o_ack1), 32'd1);
    step();
    i_req1 = 1'b0;
    chk("invalid_no_strobes", 32'({o_alloc, o_free, o_rd, o_wr}), 32'd0);
    chk("invalid_err", 32'(o_err), 32'd1);
    i_req0 = 1'b1; i_op0 = OP_ALLOC;
    bad = 0;
    repeat (4) begin
      #1 if (o_ack0 || o_ack1) bad++;
      step();
    end
    chk("halt_no_grant", 32'(bad), 32'd0);
    chk("halt_err_held", 32'(o_err), 32'd1);
    i_req0 = 1'b0;
    i_rst = 1'b1;
    #1 chk("reset_clears_err", 32'(o_err), 32'd0);
    step();
    i_rst = 1'b0;
    step();

    // allocator error in RUN suppresses the pending response
    i_req0 = 1'b1; i_op0 = OP_ALLOC; i_val0 = 16'h0055;
    #1 chk("err_run_ack", 32'(o_ack0), 32'd1);
    step();
    i_req0 = 1'b0; i_err = 1'b1;
    chk("err_run_alloc", 32'(o_alloc), 32'd1);
    step();
    i_err = 1'b0;
    chk("err_latched", 32'(o_err), 32'd1);
    chk("err_rsp_suppressed", 32'(o_rsp0), 32'd0);
    step();
    chk("err_strobes_clear", 32'(o_alloc), 32'd0);
    repeat (3) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    step();

    // reset one cycle after a grant; priority returns to client 0
    i_req0 = 1'b1; i_op0 = OP_ALLOC;
    i_req1 = 1'b1; i_op1 = OP_ALLOC;
    #1 chk("pre_reset_ack", 32'({o_ack1, o_ack0}), 32'd1);
    step();
    #1 chk("pre_reset_alloc", 32'(o_alloc), 32'd1);
    i_rst = 1'b1;
    #1 chk("mid_reset_outputs", 32'({o_alloc, o_ack0, o_ack1, o_err, o_rsp0, o_rsp1}), 32'd0);
    chk("mid_reset_data", 32'(o_data), 32'd0);
    step();
    step();
    i_rst = 1'b0;
    #1 chk("release_init_no_ack", 32'({o_ack1, o_ack0}), 32'd0);
    step();
    #1 chk("prio_after_reset", 32'({o_ack1, o_ack0}), 32'd1);
    exp_q.push_back({1'b0, 16'h5009});
    step();
    #1 chk("prio_second", 32'({o_ack1, o_ack0}), 32'd2);
    exp_q.push_back({1'b1, 16'h500A});
    step();
    i_req0 = 1'b0; i_req1 = 1'b0;
    repeat (5) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
